// File: rtl/bnn_pkg.sv
// Shared types and default sizes for the binary-multiply sequencer.
package bnn_pkg;

    localparam int unsigned ADDR_W_DEF  = 8;
    localparam int unsigned ROWS_DEF    = 7;
    localparam int unsigned RD_LAT_DEF  = 1;
    localparam int unsigned MAC_LAT_DEF = 1;
    localparam int unsigned RES_W_DEF   = 7;
    localparam int unsigned IDX_W       = 8;

    typedef logic signed [RES_W_DEF-1:0] res_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WLOAD,
        S_WDRAIN,
        S_CLR,
        S_FEED,
        S_DRAIN,
        S_OUT,
        S_FIN
    } state_e;

endpackage

// File: rtl/bnn_rd_pipe.sv
// Tracks SRAM reads in flight; each tap marks a weight or image word arriving.
module bnn_rd_pipe
    import bnn_pkg::*;
#(
    parameter int unsigned DEPTH = RD_LAT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic rd_vld,
    input  logic rd_wgt,
    output logic w_en,
    output logic img_vld
);

    logic [DEPTH-1:0] w_sr;
    logic [DEPTH-1:0] i_sr;

    // {valid, is_weight} split into two one-hot lanes so both outputs come straight from flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_sr <= '0;
            i_sr <= '0;
        end else begin
            w_sr[0] <= rd_vld & rd_wgt;
            i_sr[0] <= rd_vld & ~rd_wgt;
            for (int i = 1; i < DEPTH; i++) begin
                w_sr[i] <= w_sr[i-1];
                i_sr[i] <= i_sr[i-1];
            end
        end
    end

    assign w_en    = w_sr[DEPTH-1];
    assign img_vld = i_sr[DEPTH-1];

endmodule

// File: rtl/bnn_seq_ctrl.sv
// Sequencer: loads the weight column, then feeds 7-row image windows and
// returns one signed popcount result per window over a valid/ready port.
module bnn_seq_ctrl
    import bnn_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned ROWS    = ROWS_DEF,
    parameter int unsigned RD_LAT  = RD_LAT_DEF,
    parameter int unsigned MAC_LAT = MAC_LAT_DEF,
    parameter int unsigned RES_W   = RES_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       wgt_base,
    input  logic [ADDR_W-1:0]       img_base,
    input  logic [IDX_W-1:0]        n_win,
    output logic [ADDR_W-1:0]       addr_r,
    output logic                    w_en,
    output logic                    c_rst,
    input  logic signed [RES_W-1:0] be_in,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [RES_W-1:0] res_data,
    output logic [IDX_W-1:0]        res_idx,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned RIN_W = $clog2(ROWS + 1);
    localparam int unsigned CNT_W = $clog2(RD_LAT + MAC_LAT + 1);

    state_e              state;
    logic [ROW_W-1:0]    row;
    logic [RIN_W-1:0]    rows_in;
    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    k;
    logic [IDX_W-1:0]    n_win_q;
    logic [ADDR_W-1:0]   win_base;
    logic                rd_vld_c;
    logic                rd_wgt_c;
    logic                img_vld;

    assign rd_vld_c = (state == S_WLOAD) || (state == S_FEED);
    assign rd_wgt_c = (state == S_WLOAD);

    bnn_rd_pipe #(
        .DEPTH   (RD_LAT)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .rd_vld  (rd_vld_c),
        .rd_wgt  (rd_wgt_c),
        .w_en    (w_en),
        .img_vld (img_vld)
    );

    // addr_r is loaded on entry to a read state so it is valid in the state's first cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            addr_r    <= '0;
            c_rst     <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            row       <= '0;
            rows_in   <= '0;
            cnt       <= '0;
            k         <= '0;
            n_win_q   <= '0;
            win_base  <= '0;
        end else begin
            done  <= 1'b0;
            c_rst <= 1'b0;
            if (img_vld) begin
                rows_in <= rows_in + RIN_W'(1);
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr_r   <= wgt_base;
                        win_base <= img_base;
                        n_win_q  <= n_win;
                        row      <= '0;
                        k        <= '0;
                        busy     <= 1'b1;
                        state    <= S_WLOAD;
                    end
                end

                S_WLOAD: begin
                    if (row == ROW_W'(ROWS - 1)) begin
                        row   <= '0;
                        cnt   <= '0;
                        state <= S_WDRAIN;
                    end else begin
                        row    <= row + ROW_W'(1);
                        addr_r <= addr_r + ADDR_W'(1);
                    end
                end

                S_WDRAIN: begin
                    if (cnt == CNT_W'(RD_LAT - 1)) begin
                        if (n_win_q == '0) begin
                            done  <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            c_rst <= 1'b1;
                            state <= S_CLR;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_CLR: begin
                    addr_r  <= win_base;
                    row     <= '0;
                    rows_in <= '0;
                    state   <= S_FEED;
                end

                S_FEED: begin
                    if (row == ROW_W'(ROWS - 1)) begin
                        row   <= '0;
                        cnt   <= '0;
                        state <= S_DRAIN;
                    end else begin
                        row    <= row + ROW_W'(1);
                        addr_r <= addr_r + ADDR_W'(1);
                    end
                end

                // once every row has landed, give the datapath MAC_LAT cycles to settle
                S_DRAIN: begin
                    if (rows_in == RIN_W'(ROWS)) begin
                        if (cnt == CNT_W'(MAC_LAT - 1)) begin
                            res_data  <= be_in;
                            res_idx   <= k;
                            res_valid <= 1'b1;
                            state     <= S_OUT;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end

                S_OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        k         <= k + IDX_W'(1);
                        win_base  <= win_base + ADDR_W'(ROWS);
                        if ((k + IDX_W'(1)) == n_win_q) begin
                            done  <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            c_rst <= 1'b1;
                            state <= S_CLR;
                        end
                    end
                end

                S_FIN: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
